// File: rtl/rc_pot_scanner.sv
// Multi-channel RC-discharge pot reader: charges each node, then times its discharge.
// Optional RC_POT_SCANNER_AVG_EN adds a per-channel smoothing filter on the reported value.
module rc_pot_scanner #(
  parameter int NCH          = 4,
  parameter int CW           = 20,
  parameter int CHARGE_TICKS = 12000,
  parameter int SYNC_STAGES  = 2,
  parameter int CONTINUOUS   = 0,
  localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clki,
  input  logic           resetn,
  input  logic [NCH-1:0] pot_in,
  output logic [NCH-1:0] pot_drive,
  input  logic           start,
  output logic           busy,
  output logic           sample_valid,
  output logic [CHW-1:0] sample_ch,
  output logic [CW-1:0]  sample_value,
  output logic           sample_timeout
);

  localparam int TW = (CHARGE_TICKS > 1) ? $clog2(CHARGE_TICKS) : 1;
  localparam logic [CW-1:0] MAX_COUNT = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, STORE} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           to_q, to_d;
  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] sync_d [SYNC_STAGES];
  logic           valid_q, valid_d;
  logic [CHW-1:0] sch_q, sch_d;
  logic [CW-1:0]  sval_q, sval_d;
  logic           sto_q, sto_d;
  logic [NCH-1:0] drive;
  logic [NCH-1:0] sync_in;
  logic           meas_bit;
  logic [CW-1:0]  report_value;

  always_comb begin
    sync_d[0] = pot_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign meas_bit = sync_in[ch_q];

`ifdef RC_POT_SCANNER_AVG_EN
  // avg += (new - avg)/4 in signed arithmetic; first sample per channel seeds the filter
  logic [CW-1:0]    avg_q [NCH];
  logic [CW-1:0]    avg_d [NCH];
  logic [NCH-1:0]   seen_q, seen_d;
  logic signed [CW:0] diff, step;
  logic [CW:0]      sum;

  always_comb begin
    avg_d  = avg_q;
    seen_d = seen_q;
    diff   = $signed({1'b0, cnt_q}) - $signed({1'b0, avg_q[ch_q]});
    step   = diff >>> 2;
    sum    = {1'b0, avg_q[ch_q]} + $unsigned(step);
    if (to_q)                report_value = MAX_COUNT;
    else if (!seen_q[ch_q])  report_value = cnt_q;
    else                     report_value = sum[CW-1:0];
    if (state_q == STORE && !to_q) begin
      avg_d[ch_q]  = report_value;
      seen_d[ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clki) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) avg_q[i] <= '0;
      seen_q <= '0;
    end else begin
      avg_q  <= avg_d;
      seen_q <= seen_d;
    end
  end
`else
  assign report_value = cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    valid_d = 1'b0;
    sch_d   = sch_q;
    sval_d  = sval_q;
    sto_d   = sto_q;
    drive   = '0;
    case (state_q)
      IDLE: begin
        if (start || CONTINUOUS != 0) begin
          state_d = CHARGE;
          ch_d    = '0;
          tick_d  = '0;
        end
      end
      CHARGE: begin
        drive = NCH'(1) << ch_q;
        if (tick_q == TW'(CHARGE_TICKS - 1)) begin
          state_d = MEASURE;
          cnt_d   = '0;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      MEASURE: begin
        // A falling node wins over saturation when both happen on the same cycle
        if (!meas_bit) begin
          state_d = STORE;
          to_d    = 1'b0;
        end else if (cnt_q == MAX_COUNT) begin
          state_d = STORE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STORE: begin
        valid_d = 1'b1;
        sch_d   = ch_q;
        sval_d  = report_value;
        sto_d   = to_q;
        tick_d  = '0;
        if (ch_q == CHW'(NCH - 1)) begin
          ch_d    = '0;
          state_d = (CONTINUOUS != 0) ? CHARGE : IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = CHARGE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clki) begin
    if (!resetn) begin
      state_q <= IDLE;
      ch_q    <= '0;
      tick_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      valid_q <= 1'b0;
      sch_q   <= '0;
      sval_q  <= '0;
      sto_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      sch_q   <= sch_d;
      sval_q  <= sval_d;
      sto_q   <= sto_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign pot_drive      = drive;
  assign busy           = (state_q != IDLE);
  assign sample_valid   = valid_q;
  assign sample_ch      = sch_q;
  assign sample_value   = sval_q;
  assign sample_timeout = sto_q;

endmodule

// File: tb/tb_rc_pot_scanner.sv
// Scoreboard bench for rc_pot_scanner: an RC node model discharges a programmed number of
// cycles after pot_drive releases; expected samples are queued and popped by a monitor.
module tb_rc_pot_scanner;

  localparam int NCH  = 2;
  localparam int CW   = 8;
  localparam int CT   = 8;
  localparam int SS   = 2;
  localparam int MAXV = 255;
  localparam int HOLD = 100000;

  logic clki = 1'b0;
  always #5 clki = ~clki;

  logic           resetn, start;
  logic [NCH-1:0] pot_in, pot_drive;
  logic           busy, sample_valid, sample_timeout;
  logic [0:0]     sample_ch;
  logic [CW-1:0]  sample_value;

  logic           cont_resetn;
  logic [NCH-1:0] cont_pot_in, cont_pot_drive;
  logic           cont_busy, cont_valid, cont_timeout;
  logic [0:0]     cont_ch;
  logic [CW-1:0]  cont_value;

  rc_pot_scanner #(.NCH(NCH), .CW(CW), .CHARGE_TICKS(CT), .SYNC_STAGES(SS), .CONTINUOUS(0)) u_dut (
    .clki(clki), .resetn(resetn), .pot_in(pot_in), .pot_drive(pot_drive), .start(start),
    .busy(busy), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_value(sample_value), .sample_timeout(sample_timeout));

  rc_pot_scanner #(.NCH(NCH), .CW(CW), .CHARGE_TICKS(CT), .SYNC_STAGES(SS), .CONTINUOUS(1)) u_cont (
    .clki(clki), .resetn(cont_resetn), .pot_in(cont_pot_in), .pot_drive(cont_pot_drive),
    .start(1'b0), .busy(cont_busy), .sample_valid(cont_valid), .sample_ch(cont_ch),
    .sample_value(cont_value), .sample_timeout(cont_timeout));

  typedef struct packed {
    logic [0:0]    ch;
    logic [CW-1:0] value;
    logic          to;
  } sample_t;

  sample_t exp_q[$];
  int vec_count = 0;
  int err_count = 0;
  int delay [NCH];
  int rc [NCH];
  int cont_rc [NCH];
  int avg_m [NCH];
  bit seen_m [NCH];
  int drive_run = 0;
  bit drive_bad = 1'b0;
  int cont_seen = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      seen_m[c] = 1'b0;
      avg_m[c]  = 0;
    end
  endfunction

  // Expected reported value; the filter model is tracked in both builds
  function automatic int model_value(input int ch, input int raw, input bit to);
    int filt;
    if (to) filt = MAXV;
    else if (!seen_m[ch]) begin
      seen_m[ch] = 1'b1;
      avg_m[ch]  = raw;
      filt       = raw;
    end else begin
      avg_m[ch] = avg_m[ch] + ((raw - avg_m[ch]) >>> 2);
      filt      = avg_m[ch];
    end
`ifdef RC_POT_SCANNER_AVG_EN
    return filt;
`else
    return to ? MAXV : raw;
`endif
  endfunction

  task automatic expect_sample(input int ch, input int dly);
    sample_t e;
    int raw;
    bit to;
    raw = dly + SS;
    to  = (raw > MAXV);
    if (to) raw = MAXV;
    e.ch    = 1'(ch);
    e.value = CW'(model_value(ch, raw, to));
    e.to    = to;
    exp_q.push_back(e);
  endtask

  // RC node: charged while driven, falls dly cycles after release
  always @(negedge clki) begin
    for (int c = 0; c < NCH; c++) begin
      if (pot_drive[c]) begin
        pot_in[c] = 1'b1;
        rc[c] = 0;
      end else if (pot_in[c]) begin
        if (rc[c] >= delay[c]) pot_in[c] = 1'b0;
        else rc[c]++;
      end
      if (cont_pot_drive[c]) cont_pot_in[c] = 1'b1;
      else cont_pot_in[c] = 1'b0;
    end
  end

  always @(negedge clki) begin
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_sample", 32'(sample_valid), 32'd0);
      end else begin
        sample_t e;
        e = exp_q.pop_front();
        checkOutput("sample_ch", 32'(sample_ch), 32'(e.ch));
        checkOutput("sample_value", 32'(sample_value), 32'(e.value));
        checkOutput("sample_timeout", 32'(sample_timeout), 32'(e.to));
      end
    end
  end

  always @(negedge clki) begin
    if (pot_drive != '0) begin
      drive_run++;
      if (!$onehot(pot_drive)) drive_bad = 1'b1;
    end else if (drive_run > 0) begin
      checkOutput("drive_len", 32'(drive_run), 32'(CT));
      checkOutput("drive_onehot", 32'(drive_bad), 32'd0);
      drive_run = 0;
      drive_bad = 1'b0;
    end
  end

  always @(negedge clki) begin
    if (cont_resetn && cont_valid && cont_seen < 6) begin
      checkOutput("cont_ch", 32'(cont_ch), 32'(cont_seen % 2));
      checkOutput("cont_value", 32'(cont_value), 32'(SS));
      checkOutput("cont_timeout", 32'(cont_timeout), 32'd0);
      checkOutput("cont_busy", 32'(cont_busy), 32'd1);
      cont_seen++;
    end
  end

  task automatic check_reset_state();
    checkOutput("rst_pot_drive", 32'(pot_drive), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_ch", 32'(sample_ch), 32'd0);
    checkOutput("rst_value", 32'(sample_value), 32'd0);
    checkOutput("rst_timeout", 32'(sample_timeout), 32'd0);
  endtask

  task automatic applyStimulus(input int d0, input int d1, input bit spam);
    delay[0] = d0;
    delay[1] = d1;
    expect_sample(0, d0);
    expect_sample(1, d1);
    @(negedge clki) start = 1'b1;
    @(negedge clki) start = 1'b0;
    checkOutput("busy_rise", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 3000 && busy; cyc++) begin
      start = spam && (cyc % 7 == 3);
      @(negedge clki);
    end
    start = 1'b0;
    checkOutput("busy_fall", 32'(busy), 32'd0);
    repeat (3) @(negedge clki);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    resetn = 1'b0;
    cont_resetn = 1'b0;
    start = 1'b0;
    pot_in = '0;
    cont_pot_in = '0;
    for (int c = 0; c < NCH; c++) begin
      delay[c] = HOLD;
      rc[c] = 0;
      cont_rc[c] = 0;
    end
    model_reset();
    repeat (3) @(negedge clki);
    check_reset_state();
    resetn = 1'b1;
    cont_resetn = 1'b1;
    repeat (2) @(negedge clki);

    applyStimulus(10, 3, 1'b0);
    applyStimulus(5, HOLD, 1'b0);
    applyStimulus(0, 0, 1'b0);

    // Abort a scan in the middle of channel 0's measurement
    delay[0] = HOLD;
    delay[1] = HOLD;
    @(negedge clki) start = 1'b1;
    @(negedge clki) start = 1'b0;
    repeat (15) @(negedge clki);
    checkOutput("busy_mid_scan", 32'(busy), 32'd1);
    resetn = 1'b0;
    @(negedge clki);
    check_reset_state();
    model_reset();
    resetn = 1'b1;
    repeat (20) @(negedge clki);
    checkOutput("idle_after_abort", 32'(busy), 32'd0);

    applyStimulus(20, 40, 1'b1);
    repeat (20) @(negedge clki);
    checkOutput("idle_after_spam", 32'(busy), 32'd0);

    resetn = 1'b0;
    @(negedge clki);
    model_reset();
    resetn = 1'b1;
    @(negedge clki);
    applyStimulus(98, 0, 1'b0);
    applyStimulus(18, 0, 1'b0);

    checkOutput("cont_samples", 32'(cont_seen), 32'd6);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
